// File: rtl/serial_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: captures a byte on each rising edge of
// rx_ready_i, presents the head byte first-word-fall-through, and flags bytes dropped on full.
module serial_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  input  logic              rd_en_i,
  input  logic              clear_overrun_i,
  output logic [7:0]        data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overrun_o
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic              rdy_q;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  logic wr_stb;
  logic do_pop;
  logic do_wr;
  logic drop;

  // Strobe, accept and drop decisions, all from registered state and current inputs
  always_comb begin
    wr_stb = rx_ready_i & ~rdy_q;
    do_pop = rd_en_i & ~empty_o;
    // A pop on a full FIFO frees the slot the incoming byte lands in
    do_wr  = wr_stb & (~full_o | do_pop);
    drop   = wr_stb & full_o & ~do_pop;
  end

  // Next-state for pointers, occupancy and the sticky overrun flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (do_wr && !do_pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (do_pop && !do_wr) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
    // Set wins over a same-cycle clear
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // Control state register
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rdy_q     <= rx_ready_i;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage; cleared on reset so data_o reads 8'h00 afterwards
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= rx_data_i;
    end
  end

  // Outputs derived purely from registers
  always_comb begin
    data_o    = mem_q[rd_ptr_q];
    empty_o   = (count_q == '0);
    full_o    = (count_q == FullCount);
    count_o   = count_q;
    overrun_o = overrun_q;
  end

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_serial_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic            sysclk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      rx_data_i = 8'h00;
  logic            rx_ready_i = 1'b0;
  logic            rd_en_i = 1'b0;
  logic            clear_overrun_i = 1'b0;
  logic [7:0]      data_o;
  logic            empty_o;
  logic            full_o;
  logic [ADDR_W:0] count_o;
  logic            overrun_o;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .sysclk          (sysclk),
    .reset_n         (reset_n),
    .rx_data_i       (rx_data_i),
    .rx_ready_i      (rx_ready_i),
    .rd_en_i         (rd_en_i),
    .clear_overrun_i (clear_overrun_i),
    .data_o          (data_o),
    .empty_o         (empty_o),
    .full_o          (full_o),
    .count_o         (count_o),
    .overrun_o       (overrun_o)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       rdy;
    logic [7:0] din;
    logic       rd;
    logic [4:0] cnt;
    logic       ovr;
    logic       chk;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, return 1 time unit after it
  task automatic step(input logic rdy, input logic [7:0] din, input logic rd, input logic clr);
    rx_ready_i      = rdy;
    rx_data_i       = din;
    rd_en_i         = rd;
    clear_overrun_i = clr;
    @(posedge sysclk);
    #1;
  endtask

  task automatic apply_reset();
    rx_ready_i      = 1'b0;
    rd_en_i         = 1'b0;
    clear_overrun_i = 1'b0;
    reset_n         = 1'b0;
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
  endtask

  // One-cycle strobe followed by one idle cycle
  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_status(input string name, input int cnt, input logic ovr);
    check({name, ".count"}, 32'(count_o), 32'(cnt));
    check({name, ".empty"}, 32'(empty_o), 32'(cnt == 0));
    check({name, ".full"}, 32'(full_o), 32'(cnt == int'(DEPTH)));
    check({name, ".overrun"}, 32'(overrun_o), 32'(ovr));
  endtask

  logic [7:0] q [$];
  logic       m_ovr;
  logic       m_prev;

  initial begin
    // Vector table: {rdy, din, rd, expected count, overrun, check data?, data}
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b1, 8'hA5};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[5]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 1'b1, 8'h11};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1, 8'h11};
    vecs[12] = '{1'b1, 8'h22, 1'b1, 5'd1, 1'b0, 1'b1, 8'h22};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};

    // Reset state
    @(posedge sysclk);
    #1;
    check_status("reset", 0, 1'b0);
    check("reset.data", 32'(data_o), 32'h00);
    #3 reset_n = 1'b1;
    @(posedge sysclk);
    #1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rdy, vecs[i].din, vecs[i].rd, 1'b0);
      check_status($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].ovr);
      if (vecs[i].chk) check($sformatf("vec%0d.data", i), 32'(data_o), 32'(vecs[i].dout));
    end

    // Fill, overrun, ordered drain, sticky flag
    apply_reset();
    for (int i = 0; i < 16; i++) push(8'(i));
    check_status("fill16", 16, 1'b0);
    push(8'hFF);
    check_status("ovr17", 16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.data", i), 32'(data_o), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_status("drained", 0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovr.sticky", 32'(overrun_o), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr.cleared", 32'(overrun_o), 32'h0);

    // Full with simultaneous pop and write
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check_status("fullpopwr", 16, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fpw%0d.data", i), 32'(data_o), 32'(8'h30 + 8'(i)));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("fpw.last", 32'(data_o), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("fpw.empty", 0, 1'b0);

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) push(8'(i));
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check_status("setwins", 16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("setwins.clr", 32'(overrun_o), 32'h0);

    // Randomized run against a queue model
    apply_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b0;
    for (int c = 0; c < 600; c++) begin
      int         pct;
      logic       rdy, rd, clr, wr, pop, drop;
      logic [7:0] din;
      case ((c / 60) % 3)
        0:       pct = 15;
        1:       pct = 50;
        default: pct = 90;
      endcase
      rdy = 1'($urandom_range(0, 1));
      din = 8'($urandom_range(0, 255));
      rd  = ($urandom_range(0, 99) < pct);
      clr = ($urandom_range(0, 19) == 0);
      wr   = rdy && !m_prev;
      pop  = rd && (q.size() > 0);
      drop = wr && (q.size() == int'(DEPTH)) && !pop;
      if (pop) void'(q.pop_front());
      if (wr && !drop) q.push_back(din);
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_prev = rdy;
      step(rdy, din, rd, clr);
      check_status($sformatf("rnd%0d", c), q.size(), m_ovr);
      if (q.size() > 0) check($sformatf("rnd%0d.data", c), 32'(data_o), 32'(q[0]));
    end

    // Asynchronous reset mid-operation with count 9 and overrun set
    apply_reset();
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("premid", 9, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_status("midrst", 0, 1'b0);
    check("midrst.data", 32'(data_o), 32'h00);
    #3 reset_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check_status("postrst", 1, 1'b0);
    check("postrst.data", 32'(data_o), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
